frame_alu_sequencer: RTL

Frame-rate micro-sequencer that owns the 8×16-bit register file and drives the shared combinational `Alu`. On each `frame_start` pulse it runs a short stored program once: fetch, operand select, ALU evaluate, write-back. This replaces ad hoc per-frame register updates. It also serves a combinational display read port for `registerToPixel`, and a host port for loading the program and presetting registers.

---
 rtl/seq_pkg.sv | 59 +++++
 rtl/seq_regfile.sv | 35 +++
 rtl/frame_alu_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the frame ALU sequencer: instruction layout, FSM encoding
// and the ALU control constants used by both the sequencer and the ALU.
`timescale 1ns / 1ps

package seq_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_AW   = 3;

  // Instruction field offsets and widths.
  localparam int unsigned OPTYPE_LSB = 14;
  localparam int unsigned OPTYPE_W   = 2;
  localparam int unsigned OP_LSB     = 11;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned DST_LSB    = 8;
  localparam int unsigned SRC1_LSB   = 5;
  localparam int unsigned SRC2_LSB   = 2;
  localparam int unsigned CARRY_BIT  = 1;
  localparam int unsigned HALT_BIT   = 0;

  typedef struct packed {
    logic [OPTYPE_W-1:0] op_type;
    logic [OP_W-1:0]     op;
    logic [REG_AW-1:0]   dst;
    logic [REG_AW-1:0]   src1;
    logic [REG_AW-1:0]   src2;
    logic                use_carry;
    logic                halt;
  } instr_t;

  localparam logic [DATA_W-1:0] RESET_INSTR = 16'hC001;

  // ALU op types.
  localparam logic [1:0] LOGIC_OP   = 2'b00;
  localparam logic [1:0] ALU_OP     = 2'b01;
  localparam logic [1:0] SHIFT_OP   = 2'b10;
  localparam logic [1:0] OPTYPE_NOP = 2'b11;

  // ALU ops within LOGIC_OP.
  localparam logic [2:0] AND_OP = 3'd0;
  localparam logic [2:0] OR_OP  = 3'd1;
  localparam logic [2:0] XOR_OP = 3'd2;
  localparam logic [2:0] NOT_OP = 3'd3;

  // ALU ops within ALU_OP and SHIFT_OP.
  localparam logic [2:0] ADD_OP = 3'd0;
  localparam logic [2:0] SUB_OP = 3'd1;
  localparam logic [2:0] SHL_OP = 3'd0;
  localparam logic [2:0] SHR_OP = 3'd1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StWb    = 2'd3
  } state_e;

endpackage

// File: rtl/seq_regfile.sv
// 8x16 register file: one synchronous write port, two ALU read ports and a
// display read port, all reads combinational.
`timescale 1ns / 1ps

module seq_regfile
  import seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  input  logic [REG_AW-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic [DATA_W-1:0] o_disp_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regs <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1    = r_regs[i_raddr1];
  assign o_rdata2    = r_regs[i_raddr2];
  assign o_disp_data = r_regs[i_disp_addr];

endmodule

// File: rtl/frame_alu_sequencer.sv
// Per-frame micro-sequencer: runs the stored program once per frame_start,
// driving the external combinational ALU and writing results to the register file.
`timescale 1ns / 1ps

module frame_alu_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [15:0]                   prog_data,
  input  logic                          reg_we,
  input  logic [2:0]                    reg_addr,
  input  logic [15:0]                   reg_wdata,
  input  logic [2:0]                    disp_addr,
  output logic [15:0]                   disp_data,
  output logic [15:0]                   alu_operand1,
  output logic [15:0]                   alu_operand2,
  output logic                          alu_carry_in,
  output logic [1:0]                    alu_op_type,
  output logic [2:0]                    alu_op,
  input  logic [15:0]                   alu_result,
  input  logic                          alu_carry,
  input  logic                          alu_zero,
  input  logic                          alu_negative,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun,
  output logic                          flag_c,
  output logic                          flag_z,
  output logic                          flag_n
);

  localparam int unsigned PC_W = $clog2(PROG_DEPTH);

  state_e              r_state;
  state_e              w_state_next;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_prog [PROG_DEPTH];
  logic [1:0]          r_ir_op_type;
  logic [2:0]          r_ir_op;
  logic [REG_AW-1:0]   r_ir_dst;
  logic                r_ir_use_carry;
  logic                r_ir_halt;
  logic [DATA_W-1:0]   r_alu_op1;
  logic [DATA_W-1:0]   r_alu_op2;
  logic [DATA_W-1:0]   r_res;
  logic                r_res_c;
  logic                r_res_z;
  logic                r_res_n;
  logic                r_flag_c;
  logic                r_flag_z;
  logic                r_flag_n;
  logic                r_done;
  logic                r_overrun;

  instr_t              w_fetch;
  logic                w_busy;
  logic                w_last;
  logic                w_wb_we;
  logic                w_rf_we;
  logic [REG_AW-1:0]   w_rf_waddr;
  logic [DATA_W-1:0]   w_rf_wdata;
  logic [DATA_W-1:0]   w_rdata1;
  logic [DATA_W-1:0]   w_rdata2;

  assign w_fetch = instr_t'(r_prog[r_pc]);
  assign w_busy  = (r_state != StIdle);
  assign w_last  = r_ir_halt || (r_pc == PC_W'(PROG_DEPTH - 1));
  assign w_wb_we = (r_state == StWb) && (r_ir_op_type != OPTYPE_NOP);

  // Host writes can only land in IDLE, so they never collide with write-back.
  assign w_rf_we    = w_wb_we || (reg_we && !w_busy);
  assign w_rf_waddr = w_wb_we ? r_ir_dst : reg_addr;
  assign w_rf_wdata = w_wb_we ? r_res : reg_wdata;

  seq_regfile u_regfile (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_we        (w_rf_we),
    .i_waddr     (w_rf_waddr),
    .i_wdata     (w_rf_wdata),
    .i_raddr1    (w_fetch.src1),
    .i_raddr2    (w_fetch.src2),
    .i_disp_addr (disp_addr),
    .o_rdata1    (w_rdata1),
    .o_rdata2    (w_rdata2),
    .o_disp_data (disp_data)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (frame_start) w_state_next = StFetch;
      StFetch: w_state_next = StExec;
      StExec:  w_state_next = StWb;
      StWb:    w_state_next = w_last ? StIdle : StFetch;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PROG_DEPTH); i++) r_prog[i] <= RESET_INSTR;
    end else if (prog_we && !w_busy) begin
      r_prog[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_pc           <= '0;
      r_ir_op_type   <= '0;
      r_ir_op        <= '0;
      r_ir_dst       <= '0;
      r_ir_use_carry <= 1'b0;
      r_ir_halt      <= 1'b0;
      r_alu_op1      <= '0;
      r_alu_op2      <= '0;
      r_res          <= '0;
      r_res_c        <= 1'b0;
      r_res_z        <= 1'b0;
      r_res_n        <= 1'b0;
      r_flag_c       <= 1'b0;
      r_flag_z       <= 1'b0;
      r_flag_n       <= 1'b0;
      r_done         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == StWb) && w_last;
      if (frame_start && w_busy) r_overrun <= 1'b1;

      if (r_state == StIdle && frame_start) begin
        r_pc <= '0;
      end else if (r_state == StWb && !w_last) begin
        r_pc <= r_pc + PC_W'(1);
      end

      // Operands are read in FETCH so they are stable registers throughout EXEC.
      if (r_state == StFetch) begin
        r_ir_op_type   <= w_fetch.op_type;
        r_ir_op        <= w_fetch.op;
        r_ir_dst       <= w_fetch.dst;
        r_ir_use_carry <= w_fetch.use_carry;
        r_ir_halt      <= w_fetch.halt;
        r_alu_op1      <= w_rdata1;
        r_alu_op2      <= w_rdata2;
      end

      if (r_state == StExec) begin
        r_res   <= alu_result;
        r_res_c <= alu_carry;
        r_res_z <= alu_zero;
        r_res_n <= alu_negative;
      end

      if (w_wb_we) begin
        r_flag_c <= r_res_c;
        r_flag_z <= r_res_z;
        r_flag_n <= r_res_n;
      end
    end
  end

  assign alu_operand1 = r_alu_op1;
  assign alu_operand2 = r_alu_op2;
  assign alu_op_type  = r_ir_op_type;
  assign alu_op       = r_ir_op;
  assign alu_carry_in = r_ir_use_carry & r_flag_c;
  assign busy         = w_busy;
  assign done         = r_done;
  assign overrun      = r_overrun;
  assign flag_c       = r_flag_c;
  assign flag_z       = r_flag_z;
  assign flag_n       = r_flag_n;

endmodule
